// File: rtl/npu_byte_loader.sv
// Byte-stream loader for the NPU memory-mapped write port: packs bytes little-endian
// into 32-bit words, writes one region, optionally fires the conv trigger, then pulses done.
module npu_byte_loader #(
  parameter int IMG_SIZE = 240,
  parameter int WC_SIZE  = 9,
  parameter int FC2_SIZE = 10
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        start,
  input  logic [2:0]  cfg_sel,
  input  logic        cfg_trig,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ena,
  output logic        wea,
  output logic [15:0] addra,
  output logic [31:0] dina
);

  localparam logic [15:0] IMG_LEN = 16'(IMG_SIZE);
  localparam logic [15:0] WC_LEN  = 16'(WC_SIZE);
  localparam logic [15:0] FC2_LEN = 16'(FC2_SIZE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    TRIG  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic [2:0]  sel_q;
  logic        trig_q;
  logic [15:0] byte_cnt_q;
  logic [11:0] word_idx_q;
  logic [31:0] pack_q;

  logic        s_ready_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        ena_q;
  logic        wea_q;
  logic [15:0] addra_q;
  logic [31:0] dina_q;

  logic [15:0] len_d;
  logic [15:0] byte_inc_d;
  logic [31:0] pack_d;
  logic        sel_ok_d;
  logic        last_byte_d;

  always_comb begin
    len_d = 16'd0;
    case (sel_q)
      3'd1:    len_d = IMG_LEN;
      3'd2:    len_d = WC_LEN;
      3'd4:    len_d = FC2_LEN;
      default: len_d = 16'd0;
    endcase
  end

  // Pack register with the incoming byte already merged, so the WRITE-cycle data
  // can be registered on the same edge that accepts the last byte of a word.
  always_comb begin
    pack_d = pack_q;
    case (byte_cnt_q[1:0])
      2'd0:    pack_d[7:0]   = s_data;
      2'd1:    pack_d[15:8]  = s_data;
      2'd2:    pack_d[23:16] = s_data;
      default: pack_d[31:24] = s_data;
    endcase
  end

  assign byte_inc_d  = byte_cnt_q + 16'd1;
  assign last_byte_d = (byte_cnt_q[1:0] == 2'd3) || (byte_inc_d == len_d);
  assign sel_ok_d    = (cfg_sel == 3'd1) || (cfg_sel == 3'd2) || (cfg_sel == 3'd4);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sel_q      <= 3'd0;
      trig_q     <= 1'b0;
      byte_cnt_q <= 16'd0;
      word_idx_q <= 12'd0;
      pack_q     <= 32'd0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ena_q      <= 1'b0;
      wea_q      <= 1'b0;
      addra_q    <= 16'd0;
      dina_q     <= 32'd0;
    end else begin
      // Outputs are driven from the state being entered; default them to idle values.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= 16'd0;
      dina_q  <= 32'd0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_q      <= cfg_sel;
            trig_q     <= cfg_trig;
            byte_cnt_q <= 16'd0;
            word_idx_q <= 12'd0;
            pack_q     <= 32'd0;
            busy_q     <= 1'b1;
            if (sel_ok_d) begin
              state_q   <= RECV;
              s_ready_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        RECV: begin
          if (s_valid && s_ready_q) begin
            pack_q     <= pack_d;
            byte_cnt_q <= byte_inc_d;
            if (last_byte_d) begin
              state_q   <= WRITE;
              s_ready_q <= 1'b0;
              ena_q     <= 1'b1;
              wea_q     <= 1'b1;
              addra_q   <= {1'b0, sel_q, word_idx_q};
              dina_q    <= pack_d;
            end
          end
        end
        WRITE: begin
          word_idx_q <= word_idx_q + 12'd1;
          pack_q     <= 32'd0;
          if (byte_cnt_q < len_d) begin
            state_q   <= RECV;
            s_ready_q <= 1'b1;
          end else if (trig_q) begin
            state_q <= TRIG;
            ena_q   <= 1'b1;
            wea_q   <= 1'b1;
            addra_q <= 16'h5000;
            dina_q  <= 32'h0000_0001;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        TRIG: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ena     = ena_q;
  assign wea     = wea_q;
  assign addra   = addra_q;
  assign dina    = dina_q;

endmodule

// File: tb/tb_npu_byte_loader.sv
// Directed bench for npu_byte_loader: table of loads plus busy-start and reset-mid-load sequences.
module tb_npu_byte_loader;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cfg_sel = 3'd0;
  logic        cfg_trig = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'd0;
  logic        busy, done, err, ena, wea;
  logic [15:0] addra;
  logic [31:0] dina;

  npu_byte_loader #(.IMG_SIZE(240), .WC_SIZE(9), .FC2_SIZE(10)) dut (
    .clk(clk), .rst_ni(rst_ni), .start(start), .cfg_sel(cfg_sel), .cfg_trig(cfg_trig),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .busy(busy), .done(done),
    .err(err), .ena(ena), .wea(wea), .addra(addra), .dina(dina)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wrel_q[$];
  int          done_cnt = 0;
  int          done_rel = -1;
  logic        done_err = 1'b0;
  bit          rdy_seen = 1'b0;

  typedef struct {
    logic [2:0]  sel;
    bit          trig;
    int          n;
    logic [7:0]  base;
    bit          gaps;
    int          exp_nwr;
    bit          exp_err;
    int          exp_done_rel;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: log every write with its cycle offset from start.
  always @(negedge clk) begin
    if (ena || wea) begin
      check("wea_eq_ena", {31'd0, wea}, {31'd0, ena});
      wa_q.push_back(addra);
      wd_q.push_back(dina);
      wrel_q.push_back(cyc - start_cyc);
    end else if (addra != 16'd0 || dina != 32'd0) begin
      check("idle_bus", {addra, 16'd0} ^ dina, 32'd0);
    end
    if (done) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
      done_err = err;
    end
    if (s_ready) rdy_seen = 1'b1;
  end

  function automatic logic [31:0] model_word(input logic [7:0] base, input int n, input int w);
    logic [31:0] r = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (4 * w + j < n) r[8*j +: 8] = base + 8'(4 * w + j);
    end
    return r;
  endfunction

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    wrel_q.delete();
    done_cnt = 0;
    done_rel = -1;
    done_err = 1'b0;
    rdy_seen = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] sel, input bit trig);
    @(negedge clk);
    start = 1'b1;
    cfg_sel = sel;
    cfg_trig = trig;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] base, input bit gaps);
    int i = 0;
    int t = 0;
    while (i < n && t < 2000) begin
      @(negedge clk);
      t++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data = base + 8'(i);
        if (s_ready) i++;
      end
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
    check("feed_accepted", i, n);
  endtask

  task automatic verify(input vec_t v);
    int t = 0;
    int ntot;
    while (done_cnt == 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    ntot = v.exp_nwr + (v.trig && !v.exp_err ? 1 : 0);
    check("wr_count", wa_q.size(), ntot);
    for (int w = 0; w < v.exp_nwr && w < wa_q.size(); w++) begin
      check("wr_addr", {16'd0, wa_q[w]}, {16'd0, 1'b0, v.sel, 12'(w)});
      check("wr_data", wd_q[w], model_word(v.base, v.n, w));
    end
    if (v.exp_nwr > 0 && wa_q.size() >= v.exp_nwr) begin
      check("last_word", wd_q[v.exp_nwr - 1], v.exp_last);
      if (!v.gaps) check("first_wr_cycle", wrel_q[0], 5);
    end
    if (v.trig && !v.exp_err && wa_q.size() == ntot) begin
      check("trig_addr", {16'd0, wa_q[ntot - 1]}, 32'h0000_5000);
      check("trig_data", wd_q[ntot - 1], 32'h0000_0001);
      check("trig_cycle", wrel_q[ntot - 1], wrel_q[ntot - 2] + 1);
    end
    check("done_count", done_cnt, 1);
    check("done_err", {31'd0, done_err}, {31'd0, v.exp_err});
    if (v.exp_done_rel >= 0) check("done_cycle", done_rel, v.exp_done_rel);
    else if (wrel_q.size() > 0) check("done_after_wr", done_rel, wrel_q[wrel_q.size() - 1] + 1);
    if (v.exp_err) check("no_s_ready", {31'd0, rdy_seen}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    clear_logs();
    do_start(v.sel, v.trig);
    if (v.n > 0) begin
      feed(v.n, v.base, v.gaps);
    end else begin
      // Offer bytes anyway; none may be taken on the invalid-sel path.
      s_valid = 1'b1;
      s_data = 8'h5A;
      repeat (4) @(negedge clk);
      s_valid = 1'b0;
    end
    verify(v);
  endtask

  initial begin
    vecs[0] = '{3'd2, 1'b0, 9,   8'h01, 1'b0, 3,  1'b0, 13,  32'h0000_0009};
    vecs[1] = '{3'd4, 1'b0, 10,  8'hF0, 1'b1, 3,  1'b0, -1,  32'h0000_F9F8};
    vecs[2] = '{3'd1, 1'b1, 240, 8'h00, 1'b0, 60, 1'b0, 302, 32'hEFEE_EDEC};
    vecs[3] = '{3'd4, 1'b0, 10,  8'hF0, 1'b0, 3,  1'b0, 14,  32'h0000_F9F8};
    vecs[4] = '{3'd2, 1'b1, 9,   8'hA0, 1'b0, 3,  1'b0, 14,  32'h0000_00A8};
    vecs[5] = '{3'd3, 1'b0, 0,   8'h00, 1'b0, 0,  1'b1, 1,   32'h0};
    vecs[6] = '{3'd0, 1'b1, 0,   8'h00, 1'b0, 0,  1'b1, 1,   32'h0};
    vecs[7] = '{3'd7, 1'b0, 0,   8'h00, 1'b0, 0,  1'b1, 1,   32'h0};

    repeat (3) @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_ena_wea", {30'd0, ena, wea}, 32'd0);
    check("rst_addra", {16'd0, addra}, 32'd0);
    check("rst_dina", dina, 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      $display("vector %0d: sel=%0d trig=%0d bytes=%0d gaps=%0d", k, vecs[k].sel, vecs[k].trig,
               vecs[k].n, vecs[k].gaps);
      run_vec(vecs[k]);
    end

    // Start pulse during an active conv load must be ignored.
    $display("sequence: start while busy");
    clear_logs();
    do_start(3'd2, 1'b0);
    fork
      feed(9, 8'h01, 1'b0);
      begin
        repeat (3) @(negedge clk);
        start = 1'b1;
        cfg_sel = 3'd4;
        cfg_trig = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    verify(vecs[0]);
    repeat (5) @(negedge clk);
    check("ignored_start_idle", {31'd0, busy}, 32'd0);
    check("ignored_start_nowr", wa_q.size(), 3);

    // Reset after 5 bytes of an image load, then a clean reload from word 0.
    $display("sequence: reset mid-load");
    clear_logs();
    do_start(3'd1, 1'b0);
    feed(5, 8'h00, 1'b0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_s_ready", {31'd0, s_ready}, 32'd0);
    check("arst_ena", {30'd0, ena, wea}, 32'd0);
    check("arst_bus", dina ^ {16'd0, addra}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run_vec('{3'd1, 1'b0, 240, 8'h00, 1'b0, 60, 1'b0, 301, 32'hEFEE_EDEC});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
